// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: handshake and payload bundle between the ID/EX and EX/MEM
// boundaries of the multi-cycle execute stage. The slave modport is the stage
// itself. The master modport is whatever drives ID/EX and consumes EX/MEM.
interface ex_stage_mc_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
);
    localparam int SH_W = $clog2(XLEN);

    // ID/EX side
    logic              i_valid;
    logic              o_ready;
    logic [4:0]        i_op;
    logic              i_alusrc;
    logic              i_regdst;
    logic [XLEN-1:0]   i_pc_next;
    logic [XLEN-1:0]   i_rs_data;
    logic [XLEN-1:0]   i_rt_data;
    logic [XLEN-1:0]   i_imm;
    logic [SH_W-1:0]   i_shamt;
    logic [4:0]        i_rt_addr;
    logic [4:0]        i_rd_addr;
    logic [CTRL_W-1:0] i_ctrl;

    // EX/MEM side
    logic              o_valid;
    logic              i_ready;
    logic [XLEN-1:0]   o_alu_out;
    logic [XLEN-1:0]   o_pc_branch;
    logic              o_zero;
    logic              o_overflow;
    logic              o_illegal;
    logic [4:0]        o_reg_addr_w;
    logic [XLEN-1:0]   o_rt_data;
    logic [CTRL_W-1:0] o_ctrl;

    modport master (
        output i_valid, i_op, i_alusrc, i_regdst, i_pc_next, i_rs_data,
               i_rt_data, i_imm, i_shamt, i_rt_addr, i_rd_addr, i_ctrl, i_ready,
        input  o_ready, o_valid, o_alu_out, o_pc_branch, o_zero, o_overflow,
               o_illegal, o_reg_addr_w, o_rt_data, o_ctrl
    );

    modport slave (
        input  i_valid, i_op, i_alusrc, i_regdst, i_pc_next, i_rs_data,
               i_rt_data, i_imm, i_shamt, i_rt_addr, i_rd_addr, i_ctrl, i_ready,
        output o_ready, o_valid, o_alu_out, o_pc_branch, o_zero, o_overflow,
               o_illegal, o_reg_addr_w, o_rt_data, o_ctrl
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: parametrised MIPS execute stage with valid/ready on both sides,
// a registered EX/MEM payload and an optional iterative multiply/divide unit.
// Optional feature macro: EX_MULDIV_EN. When it is defined, HI/LO, MULT/MULTU/
// DIV/DIVU, MFHI/MFLO and the BUSY/FIX sequencing are built. When it is not
// defined, ops 12-17 are reported as illegal single-cycle ops.
module ex_stage_mc #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int SH_W   = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         rst,
    ex_stage_mc_if.slave bus
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
`ifdef EX_MULDIV_EN
    localparam logic [4:0] OP_MFHI  = 5'd12;
    localparam logic [4:0] OP_MFLO  = 5'd13;
    localparam logic [4:0] OP_MULT  = 5'd14;
    localparam logic [4:0] OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV   = 5'd16;
    localparam logic [4:0] OP_DIVU  = 5'd17;
`endif

    // Signed overflow of a+b: operands agree in sign and the sum does not.
    function automatic logic add_ovf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic [XLEN-1:0] s);
        return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
    endfunction

    // Signed overflow of a-b: operands differ in sign and the result takes b's sign.
    function automatic logic sub_ovf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic [XLEN-1:0] d);
        return (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
    endfunction

    // Two's-complement negate when n is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic n);
        return n ? ({XLEN{1'b0}} - x) : x;
    endfunction

    logic              accept;
    logic              load_sc;
    logic              is_md_p0;
    logic              ovf_p0;
    logic              ill_p0;
    logic [XLEN-1:0]   op_b_p0;
    logic [XLEN-1:0]   sum_p0;
    logic [XLEN-1:0]   diff_p0;
    logic [XLEN-1:0]   res_p0;
    logic [XLEN-1:0]   pc_branch_p0;
    logic [4:0]        waddr_p0;
    logic [SH_W-1:0]   shamt_p0;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;
    state_t            state;
    state_t            state_nxt;
    logic              md_start;
    logic              md_step;
    logic              md_fix;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_p1;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   dvd_q;
    logic              md_div_q;
    logic              md_negq_q;
    logic              md_negr_q;
    logic [SH_W-1:0]   cnt_q;
    logic [XLEN-1:0]   md_pc_q;
    logic [XLEN-1:0]   md_rt_q;
    logic [4:0]        md_waddr_q;
    logic [CTRL_W-1:0] md_ctrl_q;
    logic              md_signed;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;
`endif

    // ---- stage p0: operand select and single-cycle ALU ----
    assign shamt_p0     = bus.i_shamt;
    assign waddr_p0     = bus.i_regdst ? bus.i_rd_addr : bus.i_rt_addr;
    assign pc_branch_p0 = bus.i_pc_next + (bus.i_imm << 2);
    assign accept       = bus.i_valid && bus.o_ready;
    assign load_sc      = accept && !is_md_p0;

    // Decode the op and compute the single-cycle result, overflow and illegal flag.
    always_comb begin
        op_b_p0  = bus.i_alusrc ? bus.i_imm : bus.i_rt_data;
        sum_p0   = bus.i_rs_data + op_b_p0;
        diff_p0  = bus.i_rs_data - op_b_p0;
        res_p0   = '0;
        ovf_p0   = 1'b0;
        ill_p0   = 1'b0;
        is_md_p0 = 1'b0;
        case (bus.i_op)
            OP_ADD:  begin
                res_p0 = sum_p0;
                ovf_p0 = add_ovf(bus.i_rs_data, op_b_p0, sum_p0);
            end
            OP_SUB:  begin
                res_p0 = diff_p0;
                ovf_p0 = sub_ovf(bus.i_rs_data, op_b_p0, diff_p0);
            end
            OP_AND:  res_p0 = bus.i_rs_data & op_b_p0;
            OP_OR:   res_p0 = bus.i_rs_data | op_b_p0;
            OP_XOR:  res_p0 = bus.i_rs_data ^ op_b_p0;
            OP_NOR:  res_p0 = ~(bus.i_rs_data | op_b_p0);
            OP_SLT:  res_p0 = XLEN'($signed(bus.i_rs_data) < $signed(op_b_p0));
            OP_SLTU: res_p0 = XLEN'(bus.i_rs_data < op_b_p0);
            OP_SLL:  res_p0 = op_b_p0 << shamt_p0;
            OP_SRL:  res_p0 = op_b_p0 >> shamt_p0;
            OP_SRA:  res_p0 = $signed(op_b_p0) >>> shamt_p0;
            OP_LUI:  res_p0 = op_b_p0 << (XLEN / 2);
`ifdef EX_MULDIV_EN
            OP_MFHI: res_p0 = hi_q;
            OP_MFLO: res_p0 = lo_q;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md_p0 = 1'b1;
`endif
            default: ill_p0 = 1'b1;
        endcase
    end

`ifdef EX_MULDIV_EN
    // ---- stage p1: iterative multiply/divide ----
    assign md_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
    assign sgn_a     = md_signed && bus.i_rs_data[XLEN-1];
    assign sgn_b     = md_signed && op_b_p0[XLEN-1];

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Sequencer next state: XLEN BUSY cycles, then one FIX cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (md_start) state_nxt = S_BUSY;
            S_BUSY:  if (cnt_q == SH_W'(XLEN - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequencer outputs: upstream ready and the per-state datapath strobes.
    always_comb begin
        bus.o_ready = 1'b0;
        md_start    = 1'b0;
        md_step     = 1'b0;
        md_fix      = 1'b0;
        case (state)
            S_IDLE: begin
                bus.o_ready = !bus.o_valid || bus.i_ready;
                md_start    = bus.i_valid && bus.o_ready && is_md_p0;
            end
            S_BUSY:  md_step = 1'b1;
            S_FIX:   md_fix  = 1'b1;
            default: bus.o_ready = 1'b0;
        endcase
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    // acc_q holds {upper, lower}: {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial   = rem_sh - {1'b0, dvs_q};
        if (md_div_q)
            acc_nxt = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end

    // Sign correction and the divide-by-zero result for the FIX cycle.
    always_comb begin
        prod_p1 = md_negq_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
        if (!md_div_q) begin
            fix_hi = prod_p1[2*XLEN-1:XLEN];
            fix_lo = prod_p1[XLEN-1:0];
        end else if (dvs_q == '0) begin
            fix_hi = dvd_q;
            fix_lo = '1;
        end else begin
            fix_hi = cond_neg(acc_q[2*XLEN-1:XLEN], md_negr_q);
            fix_lo = cond_neg(acc_q[XLEN-1:0], md_negq_q);
        end
    end

    // Operand latch on start, iteration register, counter, and HI/LO commit on FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            md_div_q   <= 1'b0;
            md_negq_q  <= 1'b0;
            md_negr_q  <= 1'b0;
            cnt_q      <= '0;
            md_pc_q    <= '0;
            md_rt_q    <= '0;
            md_waddr_q <= '0;
            md_ctrl_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            if (md_start) begin
                acc_q      <= {{XLEN{1'b0}}, cond_neg(bus.i_rs_data, sgn_a)};
                dvs_q      <= cond_neg(op_b_p0, sgn_b);
                dvd_q      <= bus.i_rs_data;
                md_div_q   <= (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
                md_negq_q  <= sgn_a ^ sgn_b;
                md_negr_q  <= sgn_a;
                cnt_q      <= '0;
                md_pc_q    <= pc_branch_p0;
                md_rt_q    <= bus.i_rt_data;
                md_waddr_q <= waddr_p0;
                md_ctrl_q  <= bus.i_ctrl;
            end else if (md_step) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + 1'b1;
            end
            if (md_fix) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end
`else
    assign bus.o_ready = !bus.o_valid || bus.i_ready;
`endif

    // ---- stage p1: EX/MEM output register ----
    // Load on a single-cycle accept or a FIX cycle, drop valid when drained, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_valid      <= 1'b0;
            bus.o_alu_out    <= '0;
            bus.o_pc_branch  <= '0;
            bus.o_zero       <= 1'b0;
            bus.o_overflow   <= 1'b0;
            bus.o_illegal    <= 1'b0;
            bus.o_reg_addr_w <= '0;
            bus.o_rt_data    <= '0;
            bus.o_ctrl       <= '0;
        end else if (load_sc) begin
            bus.o_valid      <= 1'b1;
            bus.o_alu_out    <= res_p0;
            bus.o_pc_branch  <= pc_branch_p0;
            bus.o_zero       <= (res_p0 == '0);
            bus.o_overflow   <= ovf_p0;
            bus.o_illegal    <= ill_p0;
            bus.o_reg_addr_w <= waddr_p0;
            bus.o_rt_data    <= bus.i_rt_data;
            bus.o_ctrl       <= bus.i_ctrl;
`ifdef EX_MULDIV_EN
        end else if (md_fix) begin
            bus.o_valid      <= 1'b1;
            bus.o_alu_out    <= fix_lo;
            bus.o_pc_branch  <= md_pc_q;
            bus.o_zero       <= (fix_lo == '0);
            bus.o_overflow   <= 1'b0;
            bus.o_illegal    <= 1'b0;
            bus.o_reg_addr_w <= md_waddr_q;
            bus.o_rt_data    <= md_rt_q;
            bus.o_ctrl       <= md_ctrl_q;
`endif
        end else if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: scoreboard bench for ex_stage_mc. Expected beats are pushed
// when stimulus is driven and compared when the stage hands a beat downstream.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ex_stage_mc;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int TMO    = 200;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [4:0]  waddr;
        logic [31:0] rt;
        logic [7:0]  ctrl;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] rt;
        logic [31:0] imm;
        logic        alusrc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_beats = 0;
    exp_t        sb_q[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    ex_stage_mc_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    ex_stage_mc #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one op; updates the HI/LO model for mul/div.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic ovf,
                         output logic ill);
        longint s;
        logic [63:0] p;
        logic signed [31:0] q;
        logic signed [31:0] rm;
        r = '0; ovf = 1'b0; ill = 1'b0;
        p = '0; q = '0; rm = '0;
        case (op)
            5'd0: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ovf = (s != longint'($signed(r)));
            end
            5'd1: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ovf = (s != longint'($signed(r)));
            end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~(a | b);
            5'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  r = (a < b) ? 32'd1 : 32'd0;
            5'd8:  r = b << sh;
            5'd9:  r = b >> sh;
            5'd10: r = 32'($signed(b) >>> sh);
            5'd11: r = {b[15:0], 16'h0000};
`ifdef EX_MULDIV_EN
            5'd12: r = hi_m;
            5'd13: r = lo_m;
            5'd14: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_m = p[63:32]; lo_m = p[31:0]; r = lo_m;
            end
            5'd15: begin
                p = {32'h0, a} * {32'h0, b};
                hi_m = p[63:32]; lo_m = p[31:0]; r = lo_m;
            end
            5'd16: begin
                if (b == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = a; hi_m = 32'h0;
                end else begin
                    q = $signed(a) / $signed(b);
                    rm = $signed(a) % $signed(b);
                    lo_m = q; hi_m = rm;
                end
                r = lo_m;
            end
            5'd17: begin
                if (b == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = a;
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
                r = lo_m;
            end
`endif
            default: ill = 1'b1;
        endcase
    endtask

    // Drive one beat, push its expected result, hold it until the stage takes it.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rt,
                        input logic [31:0] imm, input logic alusrc);
        exp_t e;
        logic [31:0] b;
        int t;
        bus.i_op      = op;
        bus.i_rs_data = a;
        bus.i_rt_data = rt;
        bus.i_imm     = imm;
        bus.i_alusrc  = alusrc;
        bus.i_shamt   = 5'($urandom);
        bus.i_regdst  = 1'($urandom);
        bus.i_rt_addr = 5'($urandom);
        bus.i_rd_addr = 5'($urandom);
        bus.i_ctrl    = 8'($urandom);
        bus.i_pc_next = $urandom;
        bus.i_valid   = 1'b1;
        b = alusrc ? imm : rt;
        model(op, a, b, bus.i_shamt, e.alu, e.ovf, e.ill);
        e.zero  = (e.alu == 32'h0);
        e.pc    = bus.i_pc_next + (imm << 2);
        e.waddr = bus.i_regdst ? bus.i_rd_addr : bus.i_rt_addr;
        e.rt    = rt;
        e.ctrl  = bus.i_ctrl;
        sb_q.push_back(e);
        t = 0;
        #1;
        while (!bus.o_ready && t < TMO) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= TMO) check("accept_timeout", t, 0);
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Downstream side: compare every beat handed over against the scoreboard.
    always begin : monitor
        exp_t e;
        @(negedge clk); #1;
        if (!rst && bus.o_valid && bus.i_ready) begin
            n_beats++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("alu_out",   bus.o_alu_out,    e.alu);
                check("pc_branch", bus.o_pc_branch,  e.pc);
                check("zero",      bus.o_zero,       e.zero);
                check("overflow",  bus.o_overflow,   e.ovf);
                check("illegal",   bus.o_illegal,    e.ill);
                check("reg_addr",  bus.o_reg_addr_w, e.waddr);
                check("rt_data",   bus.o_rt_data,    e.rt);
                check("ctrl",      bus.o_ctrl,       e.ctrl);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   n;
        int   t;
        int   beats0;
        logic [4:0] rop;

        bus.i_valid = 1'b0; bus.i_op = '0; bus.i_alusrc = 1'b0; bus.i_regdst = 1'b0;
        bus.i_pc_next = '0; bus.i_rs_data = '0; bus.i_rt_data = '0; bus.i_imm = '0;
        bus.i_shamt = '0; bus.i_rt_addr = '0; bus.i_rd_addr = '0; bus.i_ctrl = '0;
        bus.i_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid",    bus.o_valid,      0);
        check("rst_alu_out",  bus.o_alu_out,    0);
        check("rst_illegal",  bus.o_illegal,    0);
        check("rst_pc",       bus.o_pc_branch,  0);
        check("rst_reg_addr", bus.o_reg_addr_w, 0);
        check("rst_ctrl",     bus.o_ctrl,       0);
        check("rst_ready",    bus.o_ready,      1);
        @(negedge clk);
        rst = 1'b0;

        // ADD signed overflow
        send(5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
        #1;
        check("add_valid_1edge", bus.o_valid,    1);
        check("add_result",      bus.o_alu_out,  32'h8000_0000);
        check("add_overflow",    bus.o_overflow, 1);
        check("add_zero",        bus.o_zero,     0);

        tbl = '{
            '{5'd1,  32'd5,          32'd5,          32'd0,          1'b0},
            '{5'd1,  32'h8000_0000,  32'd1,          32'd0,          1'b0},
            '{5'd0,  32'd10,         32'd0,          32'hFFFF_FFF6,  1'b1},
            '{5'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          1'b0},
            '{5'd3,  32'hF0F0_0000,  32'h0000_0F0F,  32'd0,          1'b0},
            '{5'd4,  32'hAAAA_5555,  32'hFFFF_0000,  32'd0,          1'b0},
            '{5'd5,  32'h1234_0000,  32'h0000_5678,  32'd0,          1'b0},
            '{5'd6,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
            '{5'd7,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
            '{5'd8,  32'd0,          32'h8000_0001,  32'd0,          1'b0},
            '{5'd9,  32'd0,          32'h8000_0001,  32'd0,          1'b0},
            '{5'd10, 32'd0,          32'h8000_0001,  32'd0,          1'b0},
            '{5'd11, 32'd0,          32'd0,          32'h0000_1234,  1'b1},
            '{5'd18, 32'd7,          32'd9,          32'd0,          1'b0},
            '{5'd31, 32'd7,          32'd9,          32'd0,          1'b0}
        };
        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].a, tbl[i].rt, tbl[i].imm, tbl[i].alusrc);
            #1;
            check("sc_valid_1edge", bus.o_valid, 1);
        end

        // Backpressure: three SUB beats while downstream stalls
        @(negedge clk);
        bus.i_ready = 1'b0;
        fork
            begin
                send(5'd1, 32'd50, 32'd8, 32'd0, 1'b0);
                send(5'd1, 32'd9, 32'd9, 32'd0, 1'b0);
                send(5'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                check("bp_ready_low", bus.o_ready,   0);
                check("bp_valid",     bus.o_valid,   1);
                check("bp_held_out",  bus.o_alu_out, 32'd42);
                @(negedge clk);
                bus.i_ready = 1'b1;
            end
        join

        // Random single-cycle traffic, back to back
        for (int k = 0; k < 30; k++) begin
            rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 13));
            send(rop, $urandom, $urandom, $urandom, 1'($urandom));
        end

`ifdef EX_MULDIV_EN
        // MULT -3 x 7: busy window, LO result, then MFHI
        send(5'd14, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0);
        n = 0;
        #1;
        while (!bus.o_ready && n < TMO) begin
            n++;
            @(negedge clk); #1;
        end
        check("mult_busy_cycles", n, 33);
        check("mult_valid",       bus.o_valid,   1);
        check("mult_lo",          bus.o_alu_out, 32'hFFFF_FFEB);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("mfhi_after_mult", bus.o_alu_out, 32'hFFFF_FFFF);

        send(5'd17, 32'd100, 32'd0, 32'd0, 1'b0);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("divu_by0_hi", bus.o_alu_out, 32'd100);
        send(5'd13, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("divu_by0_lo", bus.o_alu_out, 32'hFFFF_FFFF);

        send(5'd16, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("div_neg_hi", bus.o_alu_out, 32'hFFFF_FFFF);
        send(5'd13, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("div_neg_lo", bus.o_alu_out, 32'hFFFF_FFFD);

        send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        send(5'd16, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        send(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        send(5'd14, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        send(5'd16, 32'd1000, 32'hFFFF_FFF9, 32'd0, 1'b0);
        send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send(5'($urandom_range(14, 17)), $urandom, $urandom, $urandom, 1'($urandom));
            send(5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
        end

        // Reset ten cycles into a DIV discards it and clears HI/LO
        send(5'd16, 32'd12345, 32'd7, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        beats0 = n_beats;
        rst = 1'b1;
        void'(sb_q.pop_back());
        hi_m = '0;
        lo_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("rst_div_no_beat", n_beats, beats0);
        check("rst_div_ready",   bus.o_ready, 1);
        send(5'd13, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("rst_div_mflo", bus.o_alu_out, 32'd0);
`else
        // Without the mul/div unit, ops 12-17 come back illegal after one edge
        send(5'd14, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0);
        #1;
        check("mult_ill_valid", bus.o_valid,   1);
        check("mult_ill_flag",  bus.o_illegal, 1);
        check("mult_ill_out",   bus.o_alu_out, 0);
        for (int k = 12; k <= 17; k++) begin
            send(5'(k), $urandom, $urandom, $urandom, 1'b0);
        end

        // Reset while a beat is held downstream drops it at once
        @(negedge clk);
        bus.i_ready = 1'b0;
        send(5'd0, 32'd3, 32'd4, 32'd0, 1'b0);
        #1;
        check("hold_before_rst", bus.o_valid, 1);
        beats0 = n_beats;
        rst = 1'b1;
        void'(sb_q.pop_back());
        #1;
        check("async_rst_valid", bus.o_valid,   0);
        check("async_rst_out",   bus.o_alu_out, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        check("post_rst_ready", bus.o_ready, 1);
        repeat (3) @(negedge clk);
        check("rst_no_beat", n_beats, beats0);
`endif

        t = 0;
        while (sb_q.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #2;
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
